// File: rtl/axil_64to32_pkg.sv
// Shared types and helpers for the AXI4-Lite 64-to-32 bridge (write and read paths).
package axil_64to32_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE_LO = 3'd1,
    WAIT_LO  = 3'd2,
    ISSUE_HI = 3'd3,
    WAIT_HI  = 3'd4,
    RESP     = 3'd5
  } wctrl_state_t;

  localparam int unsigned HI_OFFSET = 4;

  // Encodings are ordered by severity, so the worst response is the numeric maximum.
  function automatic resp_t resp_merge(resp_t a, resp_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/whandler_master_ctrl.sv
// Write-path front end: splits one 64-bit AXI4-Lite write into lower/upper 32-bit slave writes.
// Optional build macro WHANDLER_SKIP_EMPTY_EN: halves with an all-zero strobe nibble are not issued.
module whandler_master_ctrl
  import axil_64to32_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m_awvalid,
  output logic              m_awready,
  input  logic [ADDR_W-1:0] m_awaddr,
  input  logic              m_wvalid,
  output logic              m_wready,
  input  logic [63:0]       m_wdata,
  input  logic [7:0]        m_wstrb,
  output logic              m_bvalid,
  input  logic              m_bready,
  output logic [1:0]        m_bresp,
  output logic              drv_start,
  input  logic              drv_done,
  output logic [ADDR_W-1:0] s_awaddr,
  output logic [31:0]       s_wdata,
  output logic [3:0]        s_wstrb,
  input  logic [1:0]        s_bresp
);

  wctrl_state_t      state_q;
  logic              aw_held_q, w_held_q;
  logic              awready_q, wready_q;
  logic              bvalid_q;
  resp_t             bresp_q, acc_q;
  logic              drv_start_q;
  logic [ADDR_W-1:0] s_awaddr_q, base_q;
  logic [31:0]       s_wdata_q;
  logic [3:0]        s_wstrb_q;
  logic [63:0]       wdata_q;
  logic [7:0]        wstrb_q;

  logic              aw_hs, w_hs, have_aw, have_w;
  logic [ADDR_W-1:0] base_cur;
  logic [63:0]       wdata_cur;
  logic [7:0]        wstrb_cur;
  logic              skip_lo_cur, skip_hi_cur, skip_hi_q;
  resp_t             merged;
  logic              unused_addr_lsb;

  assign aw_hs   = m_awvalid & awready_q;
  assign w_hs    = m_wvalid & wready_q;
  assign have_aw = aw_held_q | aw_hs;
  assign have_w  = w_held_q | w_hs;

  // The transaction can launch in the same cycle its last half is captured, so
  // the issue values come from the port when the capture register is not yet loaded.
  assign base_cur  = aw_held_q ? base_q : {m_awaddr[ADDR_W-1:3], 3'b000};
  assign wdata_cur = w_held_q ? wdata_q : m_wdata;
  assign wstrb_cur = w_held_q ? wstrb_q : m_wstrb;
  assign merged    = resp_merge(acc_q, resp_t'(s_bresp));

  assign unused_addr_lsb = ^m_awaddr[2:0];

`ifdef WHANDLER_SKIP_EMPTY_EN
  assign skip_lo_cur = (wstrb_cur[3:0] == 4'h0);
  assign skip_hi_cur = (wstrb_cur[7:4] == 4'h0);
  assign skip_hi_q   = (wstrb_q[7:4] == 4'h0);
`else
  assign skip_lo_cur = 1'b0;
  assign skip_hi_cur = 1'b0;
  assign skip_hi_q   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      aw_held_q   <= 1'b0;
      w_held_q    <= 1'b0;
      awready_q   <= 1'b1;
      wready_q    <= 1'b1;
      bvalid_q    <= 1'b0;
      bresp_q     <= OKAY;
      acc_q       <= OKAY;
      drv_start_q <= 1'b0;
      s_awaddr_q  <= '0;
      s_wdata_q   <= '0;
      s_wstrb_q   <= '0;
      base_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
    end else begin
      drv_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (aw_hs) begin
            aw_held_q <= 1'b1;
            awready_q <= 1'b0;
            base_q    <= base_cur;
          end
          if (w_hs) begin
            w_held_q <= 1'b1;
            wready_q <= 1'b0;
            wdata_q  <= m_wdata;
            wstrb_q  <= m_wstrb;
          end
          if (have_aw && have_w) begin
            if (!skip_lo_cur) begin
              state_q     <= ISSUE_LO;
              drv_start_q <= 1'b1;
              s_awaddr_q  <= base_cur;
              s_wdata_q   <= wdata_cur[31:0];
              s_wstrb_q   <= wstrb_cur[3:0];
            end else if (!skip_hi_cur) begin
              state_q     <= ISSUE_HI;
              acc_q       <= OKAY;
              drv_start_q <= 1'b1;
              s_awaddr_q  <= base_cur + ADDR_W'(HI_OFFSET);
              s_wdata_q   <= wdata_cur[63:32];
              s_wstrb_q   <= wstrb_cur[7:4];
            end else begin
              state_q  <= RESP;
              acc_q    <= OKAY;
              bvalid_q <= 1'b1;
              bresp_q  <= OKAY;
            end
          end
        end
        ISSUE_LO: state_q <= WAIT_LO;
        WAIT_LO: begin
          if (drv_done) begin
            acc_q <= resp_t'(s_bresp);
            if (!skip_hi_q) begin
              state_q     <= ISSUE_HI;
              drv_start_q <= 1'b1;
              s_awaddr_q  <= base_q + ADDR_W'(HI_OFFSET);
              s_wdata_q   <= wdata_q[63:32];
              s_wstrb_q   <= wstrb_q[7:4];
            end else begin
              state_q  <= RESP;
              bvalid_q <= 1'b1;
              bresp_q  <= resp_t'(s_bresp);
            end
          end
        end
        ISSUE_HI: state_q <= WAIT_HI;
        WAIT_HI: begin
          if (drv_done) begin
            state_q  <= RESP;
            acc_q    <= merged;
            bvalid_q <= 1'b1;
            bresp_q  <= merged;
          end
        end
        RESP: begin
          if (m_bready) begin
            state_q   <= IDLE;
            bvalid_q  <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_awready = awready_q;
  assign m_wready  = wready_q;
  assign m_bvalid  = bvalid_q;
  assign m_bresp   = bresp_q;
  assign drv_start = drv_start_q;
  assign s_awaddr  = s_awaddr_q;
  assign s_wdata   = s_wdata_q;
  assign s_wstrb   = s_wstrb_q;

endmodule

// File: tb/tb_whandler_master_ctrl.sv
// Bench for whandler_master_ctrl: vector table of full writes plus backpressure and reset sequences.
module tb_whandler_master_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m_awvalid = 1'b0, m_wvalid = 1'b0, m_bready = 1'b0;
  logic [31:0] m_awaddr = '0;
  logic [63:0] m_wdata = '0;
  logic [7:0]  m_wstrb = '0;
  logic        m_awready, m_wready, m_bvalid, drv_start;
  logic [1:0]  m_bresp;
  logic        drv_done = 1'b0;
  logic [1:0]  s_bresp = 2'd0;
  logic [31:0] s_awaddr, s_wdata;
  logic [3:0]  s_wstrb;

  whandler_master_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .drv_start(drv_start), .drv_done(drv_done),
    .s_awaddr(s_awaddr), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_bresp(s_bresp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Slave-driver model: records each launch, checks the slave bus stays put,
  // and answers with drv_done three cycles later using the per-half response.
  logic [31:0] rec_addr [0:255];
  logic [31:0] rec_data [0:255];
  logic [3:0]  rec_strb [0:255];
  int          rec_cyc  [0:255];
  int          done_cyc [0:255];
  int          n_issue = 0;
  int          dcnt = 0;
  logic        prev_start = 1'b0;
  logic [1:0]  cur_rlo = 2'd0, cur_rhi = 2'd0;

  always @(negedge clk) begin
    if (!rst_n) begin
      dcnt = 0;
      drv_done = 1'b0;
      s_bresp = 2'd0;
      prev_start = 1'b0;
    end else begin
      drv_done = 1'b0;
      s_bresp = 2'd0;
      if (dcnt > 0) begin
        chk("s_hold_addr", s_awaddr, rec_addr[n_issue-1]);
        chk("s_hold_data", s_wdata, rec_data[n_issue-1]);
        chk("s_hold_strb", s_wstrb, rec_strb[n_issue-1]);
        if (dcnt == 1) begin
          drv_done = 1'b1;
          s_bresp = s_awaddr[2] ? cur_rhi : cur_rlo;
          done_cyc[n_issue-1] = cyc + 1;
        end
        dcnt--;
      end
      if (drv_start) begin
        chk("start_pulse", prev_start, 0);
        rec_addr[n_issue] = s_awaddr;
        rec_data[n_issue] = s_wdata;
        rec_strb[n_issue] = s_wstrb;
        rec_cyc[n_issue]  = cyc;
        n_issue++;
        dcnt = 3;
      end
      prev_start = drv_start;
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    int          aw_dly;
    int          w_dly;
    logic [1:0]  rlo;
    logic [1:0]  rhi;
    int          exp_n;
    logic [31:0] ea0;
    logic [31:0] ed0;
    logic [3:0]  es0;
    logic [31:0] ea1;
    logic [31:0] ed1;
    logic [3:0]  es1;
    logic [1:0]  eresp;
  } vec_t;

  vec_t vecs [0:8];

  task automatic do_txn(input vec_t v, input int hold);
    int   base, k, hs_cyc, bv_cyc;
    bit   aw_done, w_done, got;
    base = n_issue;
    cur_rlo = v.rlo;
    cur_rhi = v.rhi;
    aw_done = 0; w_done = 0; got = 0; k = 0; hs_cyc = 0; bv_cyc = 0;
    while (!(aw_done && w_done) && k < 20) begin
      @(negedge clk);
      m_awvalid = !aw_done && (k >= v.aw_dly);
      m_awaddr  = v.addr;
      m_wvalid  = !w_done && (k >= v.w_dly);
      m_wdata   = v.data;
      m_wstrb   = v.strb;
      if (m_awvalid && m_awready) begin aw_done = 1; hs_cyc = cyc + 1; end
      if (m_wvalid && m_wready) begin w_done = 1; hs_cyc = cyc + 1; end
      k++;
    end
    chk("aw_w_accepted", {aw_done, w_done}, 2'b11);
    m_bready = (hold == 0);
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      m_awvalid = 1'b0;
      m_wvalid  = 1'b0;
      if (m_bvalid) begin got = 1; bv_cyc = cyc; end
    end
    chk("bvalid_seen", got, 1);
    if (got) begin
      chk("bresp", m_bresp, v.eresp);
      for (int h = 0; h < hold; h++) begin
        m_awvalid = 1'b1;
        m_awaddr  = 32'h0000BAD0;
        @(negedge clk);
        chk("hold_bvalid", m_bvalid, 1);
        chk("hold_bresp", m_bresp, v.eresp);
        chk("hold_awready", m_awready, 0);
      end
      m_awvalid = 1'b0;
      m_bready  = 1'b1;
      @(negedge clk);
      m_bready = 1'b0;
      chk("after_b_bvalid", m_bvalid, 0);
      chk("after_b_awready", m_awready, 1);
      chk("after_b_wready", m_wready, 1);
    end
    chk("n_start", n_issue - base, v.exp_n);
    if (v.exp_n >= 1 && n_issue - base >= 1) begin
      chk("w0_addr", rec_addr[base], v.ea0);
      chk("w0_data", rec_data[base], v.ed0);
      chk("w0_strb", rec_strb[base], v.es0);
      chk("lat_first_start", rec_cyc[base], hs_cyc);
    end
    if (v.exp_n == 2 && n_issue - base == 2) begin
      chk("w1_addr", rec_addr[base+1], v.ea1);
      chk("w1_data", rec_data[base+1], v.ed1);
      chk("w1_strb", rec_strb[base+1], v.es1);
      chk("lat_done_to_start", rec_cyc[base+1], done_cyc[base]);
      if (got) chk("lat_done_to_bvalid", bv_cyc, done_cyc[base+1]);
    end
    if (v.exp_n == 1 && n_issue - base == 1 && got)
      chk("lat_done_to_bvalid", bv_cyc, done_cyc[base]);
    if (v.exp_n == 0 && got)
      chk("lat_capture_to_bvalid", bv_cyc, hs_cyc);
  endtask

  initial begin
    int base;
    vecs[0] = '{32'h00001008, 64'h11223344_55667788, 8'hFF, 0, 0, 2'd0, 2'd0,
                2, 32'h00001008, 32'h55667788, 4'hF, 32'h0000100C, 32'h11223344, 4'hF, 2'd0};
    vecs[1] = '{32'h00002000, 64'hAABBCCDD_00112233, 8'hFF, 3, 0, 2'd0, 2'd0,
                2, 32'h00002000, 32'h00112233, 4'hF, 32'h00002004, 32'hAABBCCDD, 4'hF, 2'd0};
    vecs[2] = '{32'h00000030, 64'h00000001_00000002, 8'hFF, 0, 0, 2'd2, 2'd0,
                2, 32'h00000030, 32'h00000002, 4'hF, 32'h00000034, 32'h00000001, 4'hF, 2'd2};
    vecs[3] = '{32'h00000040, 64'hDEADBEEF_CAFEF00D, 8'hFF, 0, 0, 2'd0, 2'd3,
                2, 32'h00000040, 32'hCAFEF00D, 4'hF, 32'h00000044, 32'hDEADBEEF, 4'hF, 2'd3};
    vecs[4] = '{32'h00004007, 64'h01234567_89ABCDEF, 8'h3C, 0, 2, 2'd1, 2'd0,
                2, 32'h00004000, 32'h89ABCDEF, 4'hC, 32'h00004004, 32'h01234567, 4'h3, 2'd1};
    vecs[8] = '{32'h00000708, 64'h77777777_88888888, 8'hFF, 1, 1, 2'd3, 2'd2,
                2, 32'h00000708, 32'h88888888, 4'hF, 32'h0000070C, 32'h77777777, 4'hF, 2'd3};
`ifdef WHANDLER_SKIP_EMPTY_EN
    vecs[5] = '{32'h00000500, 64'h11111111_22222222, 8'h0F, 0, 0, 2'd0, 2'd2,
                1, 32'h00000500, 32'h22222222, 4'hF, 32'h0, 32'h0, 4'h0, 2'd0};
    vecs[6] = '{32'h00000600, 64'h33333333_44444444, 8'h00, 0, 0, 2'd1, 2'd3,
                0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 2'd0};
    vecs[7] = '{32'hFFFFFFF8, 64'h55555555_66666666, 8'hF0, 0, 0, 2'd3, 2'd2,
                1, 32'hFFFFFFFC, 32'h55555555, 4'hF, 32'h0, 32'h0, 4'h0, 2'd2};
`else
    vecs[5] = '{32'h00000500, 64'h11111111_22222222, 8'h0F, 0, 0, 2'd0, 2'd2,
                2, 32'h00000500, 32'h22222222, 4'hF, 32'h00000504, 32'h11111111, 4'h0, 2'd2};
    vecs[6] = '{32'h00000600, 64'h33333333_44444444, 8'h00, 0, 0, 2'd1, 2'd3,
                2, 32'h00000600, 32'h44444444, 4'h0, 32'h00000604, 32'h33333333, 4'h0, 2'd3};
    vecs[7] = '{32'hFFFFFFF8, 64'h55555555_66666666, 8'hF0, 0, 0, 2'd3, 2'd2,
                2, 32'hFFFFFFF8, 32'h66666666, 4'h0, 32'hFFFFFFFC, 32'h55555555, 4'hF, 2'd3};
`endif

    repeat (3) @(negedge clk);
    chk("rst_awready", m_awready, 1);
    chk("rst_wready", m_wready, 1);
    chk("rst_bvalid", m_bvalid, 0);
    chk("rst_bresp", m_bresp, 0);
    chk("rst_drv_start", drv_start, 0);
    chk("rst_s_bus", {s_wstrb, s_wdata, s_awaddr}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) do_txn(vecs[i], 0);

    // Response held off by the master for five cycles with a competing AW pending.
    do_txn(vecs[2], 5);
    do_txn(vecs[0], 0);

    // Asynchronous reset while the upper half is outstanding.
    base = n_issue;
    cur_rlo = 2'd0;
    cur_rhi = 2'd0;
    @(negedge clk);
    m_awvalid = 1'b1; m_awaddr = 32'h00009000;
    m_wvalid = 1'b1; m_wdata = 64'hFEDCBA98_76543210; m_wstrb = 8'hFF;
    @(negedge clk);
    m_awvalid = 1'b0; m_wvalid = 1'b0;
    for (int t = 0; t < 20 && n_issue - base < 2; t++) @(negedge clk);
    chk("rst_reach_issue_hi", n_issue - base, 2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_awready", m_awready, 1);
    chk("midrst_wready", m_wready, 1);
    chk("midrst_bvalid", m_bvalid, 0);
    chk("midrst_bresp", m_bresp, 0);
    chk("midrst_drv_start", drv_start, 0);
    chk("midrst_s_bus", {s_wstrb, s_wdata, s_awaddr}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_bvalid", m_bvalid, 0);
    do_txn(vecs[3], 0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/whandler_master_ctrl.md
# whandler_master_ctrl

Write-path front end of the AXI4-Lite 64-to-32 bridge. Accepts one 64-bit AXI4-Lite write from the upstream master and splits it into up to two 32-bit writes: lower word first, then upper. Each write is handed to the downstream `whandler_slave_driver` through a start/done handshake. The block merges the two slave responses and returns a single write response to the master.

## Interface
Parameters:
- `ADDR_W`, 32 — address width on both sides.

Ports (reset `rst_n`, asynchronous, active-low; clock `clk`):
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `m_awvalid`  in  1  master write-address valid
- `m_awready`  out  1  master write-address ready
- `m_awaddr`  in  ADDR_W  master write address
- `m_wvalid`  in  1  master write-data valid
- `m_wready`  out  1  master write-data ready
- `m_wdata`  in  64  master write data
- `m_wstrb`  in  8  master byte strobes
- `m_bvalid`  out  1  master response valid
- `m_bready`  in  1  master response ready
- `m_bresp`  out  2  merged response
- `drv_start`  out  1  one-cycle pulse: launch a slave write
- `drv_done`  in  1  one-cycle pulse from driver: slave B handshake completed
- `s_awaddr`  out  ADDR_W  slave address, held stable from `drv_start` until `drv_done`
- `s_wdata`  out  32  slave data, held stable with `s_awaddr`
- `s_wstrb`  out  4  slave strobes, held stable with `s_awaddr`
- `s_bresp`  in  2  slave response, sampled only in the cycle `drv_done`=1

## Operation
FSM states and transitions:
- `IDLE`: `m_awready`=1 until AW is captured; `m_wready`=1 until W is captured. AW and W are captured independently and may arrive in either order or in the same cycle. When both are held, go to `ISSUE_LO`.
- `ISSUE_LO`:
  - Drive `s_awaddr`={awaddr[ADDR_W-1:3],3'b000}, `s_wdata`=wdata[31:0], `s_wstrb`=wstrb[3:0].
  - Pulse `drv_start`, then go to `WAIT_LO`.
- `WAIT_LO`: on `drv_done`, set acc=`s_bresp` and go to `ISSUE_HI`.
- `ISSUE_HI`:
  - Drive `s_awaddr`=base+4, `s_wdata`=wdata[63:32], `s_wstrb`=wstrb[7:4].
  - Pulse `drv_start`, then go to `WAIT_HI`.
- `WAIT_HI`: on `drv_done`, set acc=max(acc,`s_bresp`) and go to `RESP`.
- `RESP`: `m_bvalid`=1 and `m_bresp`=acc. On `m_bready`, return to `IDLE` and clear both capture flags.

Rules:
- Response merge is the numeric maximum: DECERR(3) > SLVERR(2) > EXOKAY(1) > OKAY(0).
- `m_awaddr[2:0]` is ignored.
- A `drv_done` outside `WAIT_LO`/`WAIT_HI` is ignored.
- In `IDLE`, `m_awready`/`m_wready` drop in the cycle after the respective capture. No new AW or W is accepted until `RESP` completes, so at most one transaction is outstanding.

## Timing
- Reset values:
  - FSM `IDLE`; capture flags 0; acc=0.
  - `m_awready`=1, `m_wready`=1, `m_bvalid`=0, `m_bresp`=0.
  - `drv_start`=0, `s_awaddr`=0, `s_wdata`=0, `s_wstrb`=0.
- `drv_start` is registered and high for exactly one cycle per issue state.
- All `s_*` outputs are registered and change only on entry to `ISSUE_LO` or `ISSUE_HI`.
- Latency:
  - Last of AW/W handshake to first `drv_start` = 1 cycle.
  - `drv_done` to next `drv_start` = 1 cycle.
  - Final `drv_done` to `m_bvalid` = 1 cycle.
- `m_bvalid` and `m_bresp` hold until `m_bready`. In `RESP` with `m_bready` already high, the block is back in `IDLE` the next cycle.
- Reset mid-operation returns all state and outputs to reset values. The driver must be reset from the same `rst_n`.

## Configuration
- `WHANDLER_SKIP_EMPTY_EN` defined:
  - A half whose strobe nibble is 0 is not issued; its issue state is skipped and it contributes OKAY.
  - If both nibbles are 0, go from capture directly to `RESP` with OKAY. `m_bvalid` then rises 1 cycle after the last capture.
- `WHANDLER_SKIP_EMPTY_EN` undefined: both halves are always issued, including all-zero strobes.

## Structure
- Shared package `axil_64to32_pkg` holds:
  - the `resp_t` enum (OKAY/EXOKAY/SLVERR/DECERR)
  - the `wctrl_state_t` state enum
  - the constant `HI_OFFSET`=4
  - the function `resp_merge(resp_t a, resp_t b)`
- No sub-module. `whandler_master_ctrl` and `whandler_slave_driver` are siblings, connected by the bridge top.

## Test plan
- AW 0x1008 and W 0x11223344_55667788 / strb 0xFF in the same cycle → slave writes (0x1008, 0x55667788, 0xF) then (0x100C, 0x11223344, 0xF); `m_bresp`=OKAY.
- W arrives 3 cycles before AW → exactly two `drv_start` pulses, first one cycle after the AW handshake.
- Lower half returns SLVERR, upper returns OKAY → `m_bresp`=SLVERR. Lower OKAY, upper DECERR → `m_bresp`=DECERR.
- `m_bready` held low 5 cycles in `RESP` → `m_bvalid`/`m_bresp` stable; `m_awready`=0 and a second AW is not accepted until the B handshake completes.
- strb 0x0F with `WHANDLER_SKIP_EMPTY_EN` → one `drv_start`, to address base. strb 0x00 → zero `drv_start`, OKAY. With the macro undefined, both cases → two `drv_start`.
- `rst_n` asserted during `WAIT_HI` → all outputs at reset values immediately. After release, a fresh write completes normally.
